nr_div_array: RTL and testbench
===============================

// Module: nr_div_array
// PURPOSE
//  Multi-channel signed fixed-point divider using Newton-Raphson reciprocal refinement.
//  One multiplier datapath is shared round-robin across CHANNELS lanes; this replaces one divider instance per lane.
//  A load pulse captures every lane's operands. After a fixed latency, done pulses and all quotients are valid together.
// PARAMETERS
//  WIDTH    16  operand/result width, signed two's complement, Q(WIDTH-FRAC).FRAC
//  FRAC     8   fractional bits (1.0 = 2**FRAC)
//  CHANNELS 9   number of lanes
//  ITERS    4   Newton-Raphson iterations per lane
// PORTS
//  clk           in   1                 rising-edge clock, single domain
//  rst_n         in   1                 asynchronous active-low reset
//  load          in   1                 start request, sampled on posedge clk
//  nr            in   CHANNELS*WIDTH    numerators, lane i at [i*WIDTH +: WIDTH]
//  dr            in   CHANNELS*WIDTH    divisors, same packing
//  initial_guess in   CHANNELS*WIDTH    seed for 1/|dr|, positive, same packing
//  busy          out  1                 high from the cycle after load is accepted until done
//  done          out  1                 one-cycle pulse when all lanes are written
//  div_res       out  CHANNELS*WIDTH    quotients, registered
//  div_by_zero   out  CHANNELS          per-lane flag: dr was 0 at load
// BEHAVIOUR
//  Reset (async): busy=0, done=0, div_res=0, div_by_zero=0, FSM to IDLE, internal registers cleared.
//  load accepted only in IDLE. load while busy is ignored (no restart, no effect on results).
//  On accept: capture all nr/dr/initial_guess, store |nr|, |dr| and sign=nr^dr per lane. ch=0. Enter RUN.
//  FSM states:
//   IDLE -> RUN on load.
//   RUN per lane: x=guess[ch]. Then ITERS pairs of cycles:
//     DX: t = mul(|d|, x)
//     XU: x = mul(x, 2.0 - t)
//   QM: q = mul(|n|, x); div_res[ch] <= sign ? -q : q. Then ch++.
//   After lane CHANNELS-1 finishes QM, go to DONE.
//   DONE: done=1 for one cycle, busy=0, back to IDLE.
//  Latency: each lane takes 2*ITERS+1 cycles.
//   The done pulse falls CHANNELS*(2*ITERS+1)+1 cycles after the accepting edge (default 82).
//  mul(a,b): full 2*WIDTH signed product, arithmetic shift right by FRAC (truncation),
//   then saturate to [-(2**(WIDTH-1)), 2**(WIDTH-1)-1].
//  Magnitude of -2**(WIDTH-1) saturates to 2**(WIDTH-1)-1.
//  dr==0 lane:
//   The lane still consumes its full cycle slot, so latency stays fixed.
//   div_res = +max if nr>=0, otherwise -max (= -(2**(WIDTH-1)-1)). div_by_zero[ch]=1.
//  div_res lanes update one at a time as their QM completes. Lanes not yet reached keep their previous values.
//  All lanes are stable from done until the next accepted load.
//  div_by_zero is updated at accept and held until the next accept.
//  Reset mid-run: immediate abort, all outputs return to reset values, no done pulse.
//  load asserted during the DONE cycle is ignored. load in the first IDLE cycle after DONE is accepted.
//  Inputs may change freely after the accepting edge.
// STRUCTURE
//  Shared package nr_div_pkg:
//   state encoding (IDLE, RUN, DONE)
//   phase encoding (DX, XU, QM)
//   ONE = 1<<FRAC, TWO = 2<<FRAC
//   MAXP / MINN saturation constants as functions of WIDTH
//  Sub-module nr_mul_q (combinational): signed multiply, shift by FRAC, saturate. Parameters WIDTH, FRAC.
//   Instantiated once.
//  Top level holds the FSM, lane counter, iteration counter, operand register files and result registers.
// TESTING (WIDTH=16, FRAC=8, ITERS=4, CHANNELS=9)
//  T1: nr=768 (3.0), dr=512 (2.0), guess=128 -> div_res=384 (1.5); done exactly 82 cycles after accept.
//  T2: nr=256, dr=768, guess=64 -> div_res=85; lane with nr=-768, dr=512, guess=128 -> -384.
//  T3: dr=0 with nr=100 -> 32767, div_by_zero=1; dr=0 with nr=-5 -> -32767, div_by_zero=1;
//      latency still 82 cycles.
//  T4: load pulsed at cycle 20 of a run -> ignored. Results and done timing match the single-load run.
//      A second load one cycle after done starts a new run.
//  T5: deassert rst_n mid-run (cycle 40) -> busy/done/div_res/div_by_zero go to 0 at once; no done pulse;
//      after release, a fresh load gives correct results.
//  T6: all 9 lanes with distinct values: results written in lane order;
//      the bench compares against a bit-accurate reference model of the same mul() rule.

Source files
------------

// File: rtl/nr_div_pkg.sv
// Shared encodings and fixed-point helpers for the Newton-Raphson divider array.
package nr_div_pkg;

    // Top-level controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Per-lane datapath phase: t = d*x, x = x*(2-t), q = n*x
    typedef enum logic [1:0] {
        PH_DX = 2'd0,
        PH_XU = 2'd1,
        PH_QM = 2'd2
    } phase_t;

    // 1.0 in a format with frac fractional bits
    function automatic longint one_q(input int frac);
        return longint'(1) << frac;
    endfunction

    // 2.0 in a format with frac fractional bits
    function automatic longint two_q(input int frac);
        return longint'(2) << frac;
    endfunction

    // Largest positive value of a width-bit two's complement word
    function automatic longint sat_max(input int width);
        return (longint'(1) << (width - 1)) - 1;
    endfunction

    // Most negative value of a width-bit two's complement word
    function automatic longint sat_min(input int width);
        return -(longint'(1) << (width - 1));
    endfunction

endpackage

// File: rtl/nr_div_array_mul.sv
// Shared fixed-point multiplier: full signed product, truncating shift by FRAC,
// then saturation back into WIDTH bits.
module nr_mul_q
    import nr_div_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] p
);

    localparam int WW = 2 * WIDTH;
    localparam logic signed [WW-1:0]    MAXP_W = WW'(sat_max(WIDTH));
    localparam logic signed [WW-1:0]    MINN_W = WW'(sat_min(WIDTH));
    localparam logic signed [WIDTH-1:0] MAXP   = WIDTH'(sat_max(WIDTH));
    localparam logic signed [WIDTH-1:0] MINN   = WIDTH'(sat_min(WIDTH));

    logic signed [WW-1:0] full;
    logic signed [WW-1:0] shifted;

    // Product, arithmetic shift (rounds toward -inf), clamp to WIDTH range
    always_comb begin
        full    = WW'(a) * WW'(b);
        shifted = full >>> FRAC;
        if (shifted > MAXP_W)
            p = MAXP;
        else if (shifted < MINN_W)
            p = MINN;
        else
            p = shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/nr_div_array.sv
// Multi-lane signed fixed-point divider. One nr_mul_q is time-shared across all
// lanes; each lane runs ITERS Newton-Raphson refinements of 1/|d| and then one
// quotient multiply, giving a fixed CHANNELS*(2*ITERS+1) cycle run.
module nr_div_array
    import nr_div_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int FRAC     = 8,
    parameter int CHANNELS = 9,
    parameter int ITERS    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [CHANNELS*WIDTH-1:0] nr,
    input  logic [CHANNELS*WIDTH-1:0] dr,
    input  logic [CHANNELS*WIDTH-1:0] initial_guess,
    output logic                      busy,
    output logic                      done,
    output logic [CHANNELS*WIDTH-1:0] div_res,
    output logic [CHANNELS-1:0]       div_by_zero
);

    localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int ITW = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic signed [WIDTH-1:0] MAXP  = WIDTH'(sat_max(WIDTH));
    localparam logic signed [WIDTH-1:0] MINN  = WIDTH'(sat_min(WIDTH));
    localparam logic signed [WIDTH-1:0] TWO_Q = WIDTH'(two_q(FRAC));

    state_t state;
    phase_t phase;
    logic [CHW-1:0] ch;
    logic [ITW-1:0] iter;

    logic signed [WIDTH-1:0] mag_n [CHANNELS];
    logic signed [WIDTH-1:0] mag_d [CHANNELS];
    logic signed [WIDTH-1:0] guess [CHANNELS];
    logic [CHANNELS-1:0]     sgn;
    logic signed [WIDTH-1:0] x;
    logic signed [WIDTH-1:0] t;

    logic signed [WIDTH-1:0] mul_a;
    logic signed [WIDTH-1:0] mul_b;
    logic signed [WIDTH-1:0] prod;
    logic signed [WIDTH-1:0] lane_q;

    // |v| with the most negative code clamped to +max
    function automatic logic signed [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
        if (v == MINN)
            return MAXP;
        else if (v[WIDTH-1])
            return -v;
        else
            return v;
    endfunction

    nr_mul_q #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul (
        .a(mul_a),
        .b(mul_b),
        .p(prod)
    );

    // Operand select for the shared multiplier; the seed is used directly on the first DX
    always_comb begin
        mul_a = mag_d[ch];
        mul_b = x;
        case (phase)
            PH_DX: begin
                mul_a = mag_d[ch];
                mul_b = (iter == ITW'(0)) ? guess[ch] : x;
            end
            PH_XU: begin
                mul_a = x;
                mul_b = TWO_Q - t;
            end
            PH_QM: begin
                mul_a = mag_n[ch];
                mul_b = x;
            end
            default: ;
        endcase
    end

    // Signed lane result; zero divisors force a saturated quotient of the numerator's sign
    always_comb begin
        if (div_by_zero[ch])
            lane_q = sgn[ch] ? -MAXP : MAXP;
        else if (sgn[ch])
            lane_q = (prod == MINN) ? MAXP : -prod;
        else
            lane_q = prod;
    end

    // Controller, lane/iteration sequencing and result write-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            phase       <= PH_DX;
            ch          <= '0;
            iter        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_res     <= '0;
            div_by_zero <= '0;
            sgn         <= '0;
            x           <= '0;
            t           <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                mag_n[i] <= '0;
                mag_d[i] <= '0;
                guess[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        for (int i = 0; i < CHANNELS; i++) begin
                            mag_n[i]       <= mag(nr[i*WIDTH +: WIDTH]);
                            mag_d[i]       <= mag(dr[i*WIDTH +: WIDTH]);
                            guess[i]       <= initial_guess[i*WIDTH +: WIDTH];
                            sgn[i]         <= nr[i*WIDTH+WIDTH-1] ^ dr[i*WIDTH+WIDTH-1];
                            div_by_zero[i] <= (dr[i*WIDTH +: WIDTH] == '0);
                        end
                        state <= ST_RUN;
                        phase <= PH_DX;
                        ch    <= '0;
                        iter  <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    case (phase)
                        PH_DX: begin
                            t <= prod;
                            if (iter == ITW'(0))
                                x <= guess[ch];
                            phase <= PH_XU;
                        end
                        PH_XU: begin
                            x <= prod;
                            if (iter == ITW'(ITERS - 1)) begin
                                iter  <= '0;
                                phase <= PH_QM;
                            end else begin
                                iter  <= iter + ITW'(1);
                                phase <= PH_DX;
                            end
                        end
                        PH_QM: begin
                            div_res[ch*WIDTH +: WIDTH] <= lane_q;
                            phase <= PH_DX;
                            if (ch == CHW'(CHANNELS - 1)) begin
                                ch    <= '0;
                                state <= ST_DONE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                ch <= ch + CHW'(1);
                            end
                        end
                        default: phase <= PH_DX;
                    endcase
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nr_div_array.sv
// Testbench for nr_div_array: table-driven lane vectors with a result scoreboard,
// plus sequences for load-while-busy, back-to-back load and mid-run reset.
module tb_nr_div_array;

    localparam int W   = 16;
    localparam int F   = 8;
    localparam int CH  = 9;
    localparam int IT  = 4;
    localparam int SLOT = 2 * IT + 1;
    localparam int LAT = CH * SLOT;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load = 1'b0;
    logic [CH*W-1:0] nr_bus = '0;
    logic [CH*W-1:0] dr_bus = '0;
    logic [CH*W-1:0] g_bus = '0;
    logic [CH*W-1:0] div_res;
    logic busy, done;
    logic [CH-1:0] div_by_zero;

    nr_div_array #(.WIDTH(W), .FRAC(F), .CHANNELS(CH), .ITERS(IT)) dut (
        .clk(clk), .rst_n(rst_n), .load(load),
        .nr(nr_bus), .dr(dr_bus), .initial_guess(g_bus),
        .busy(busy), .done(done), .div_res(div_res), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct { int n; int d; int g; int q; bit dz; } vec_t;
    typedef struct { int lane; int q; bit dz; } exp_t;

    vec_t tbl[CH];
    exp_t sb[$];
    int   lane_exp[CH];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference fixed-point arithmetic
    function automatic int mulq(input int a, input int b);
        longint p;
        p = longint'(a) * longint'(b);
        p = p >>> F;
        if (p > 32767) p = 32767;
        if (p < -32768) p = -32768;
        return int'(p);
    endfunction

    function automatic int magq(input int v);
        if (v == -32768) return 32767;
        return (v < 0) ? -v : v;
    endfunction

    function automatic int ref_div(input int n, input int d, input int g);
        int an, ad, x, t, q;
        bit neg;
        neg = (n < 0) ^ (d < 0);
        if (d == 0) return (n >= 0) ? 32767 : -32767;
        an = magq(n);
        ad = magq(d);
        x  = g;
        for (int k = 0; k < IT; k++) begin
            t = mulq(ad, x);
            x = mulq(x, int'(shortint'((2 << F) - t)));
        end
        q = mulq(an, x);
        if (neg) q = (q == -32768) ? 32767 : -q;
        return q;
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic set_lane(input int i, input int n, input int d, input int g, input int q);
        tbl[i] = '{n: n, d: d, g: g, q: q, dz: (d == 0)};
    endtask

    task automatic set_lane_model(input int i, input int n, input int d, input int g);
        set_lane(i, n, d, g, ref_div(n, d, g));
    endtask

    task automatic drive_table();
        for (int i = 0; i < CH; i++) begin
            nr_bus[i*W +: W] = W'(tbl[i].n);
            dr_bus[i*W +: W] = W'(tbl[i].d);
            g_bus[i*W +: W]  = W'(tbl[i].g);
        end
    endtask

    task automatic push_expected();
        for (int i = 0; i < CH; i++) begin
            sb.push_back('{lane: i, q: tbl[i].q, dz: tbl[i].dz});
            lane_exp[i] = tbl[i].q;
        end
    endtask

    task automatic launch();
        @(negedge clk);
        drive_table();
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        push_expected();
        check("busy_after_accept", busy, 1);
    endtask

    task automatic wait_done(input int inject_at, input bit chk_order, output int cyc);
        cyc = 0;
        while (cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (chk_order && (cyc % SLOT == 0) && cyc <= LAT) begin
                int ln;
                ln = cyc / SLOT - 1;
                check($sformatf("lane%0d_in_order", ln), $signed(div_res[ln*W +: W]), lane_exp[ln]);
            end
            if (cyc == inject_at) begin
                load   = 1'b1;
                nr_bus = ~nr_bus;
                dr_bus = ~dr_bus;
                g_bus  = ~g_bus;
            end
            if (cyc == inject_at + 1) begin
                load = 1'b0;
                check("busy_after_ignored_load", busy, 1);
            end
            if (done) return;
        end
        check("done_timeout", 1, 0);
    endtask

    task automatic finish_run(input int cyc);
        exp_t e;
        check("done_latency", cyc, LAT);
        check("busy_low_at_done", busy, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("div_res[%0d]", e.lane), $signed(div_res[e.lane*W +: W]), e.q);
            check($sformatf("div_by_zero[%0d]", e.lane), div_by_zero[e.lane], e.dz);
        end
        @(posedge clk);
        #1;
        check("done_one_cycle", done, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_div_res_zero"}, (div_res == '0), 1);
        check({tag, "_div_by_zero"}, div_by_zero, 0);
    endtask

    task automatic table_a();
        set_lane(0, 768, 512, 128, 384);
        set_lane(1, 256, 768, 64, 85);
        set_lane(2, -768, 512, 128, -384);
        set_lane(3, 100, 0, 128, 32767);
        set_lane(4, -5, 0, 128, -32767);
        set_lane_model(5, 0, 256, 256);
        set_lane_model(6, -32768, 256, 256);
        set_lane_model(7, 1280, -512, 128);
        set_lane_model(8, 512, 1024, 64);
    endtask

    initial begin
        int cyc;
        int saw_done;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // T1/T2/T3: fixed vectors incl. zero divisors and saturation
        table_a();
        launch();
        wait_done(-1, 1'b0, cyc);
        finish_run(cyc);

        // T4: load pulsed mid-run is ignored
        for (int i = 0; i < CH; i++)
            set_lane_model(i, 256 * (i + 1) - 700, 300 + 97 * i, 65536 / (300 + 97 * i));
        launch();
        wait_done(20, 1'b0, cyc);
        // raise load during the DONE cycle and hold it: ignored there, accepted next cycle
        for (int i = 0; i < CH; i++)
            set_lane_model(i, -1000 + 333 * i, 700 - 150 * i, (700 - 150 * i) != 0 ? 65536 / magq(700 - 150 * i) : 64);
        drive_table();
        load = 1'b1;
        finish_run(cyc);
        check("load_in_done_ignored", busy, 0);
        @(posedge clk);
        #1;
        load = 1'b0;
        check("load_after_done_accepted", busy, 1);
        push_expected();
        wait_done(-1, 1'b0, cyc);
        finish_run(cyc);

        // T5: reset mid-run
        table_a();
        launch();
        repeat (40) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        sb.delete();
        saw_done = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            if (done) saw_done++;
            if (k == 5) rst_n = 1'b1;
        end
        check("no_done_after_abort", saw_done, 0);
        launch();
        wait_done(-1, 1'b0, cyc);
        finish_run(cyc);

        // T6: distinct random lanes against the reference model, lane write order checked
        for (int i = 0; i < CH; i++) begin
            int d, n;
            d = int'($urandom_range(64, 4000));
            if ($urandom_range(0, 1) == 1) d = -d;
            n = int'($urandom_range(0, 8000)) - 4000;
            set_lane_model(i, n, d, 65536 / magq(d));
        end
        launch();
        wait_done(-1, 1'b1, cyc);
        finish_run(cyc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
